// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the four-client round-robin arbiter.
package arb_pkg;

  localparam int N_CLIENTS = 4;
  localparam int IDX_W     = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Rotating search starting at last+1; returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                             input logic [IDX_W-1:0]     last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = {(IDX_W+1){1'b0}};
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx = last + IDX_W'(k);
      if (!res[IDX_W] && r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the clients (master) and the arbiter (slave).
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 preempt;

  modport master (output req, input grant, grant_idx, grant_valid, preempt);
  modport slave  (input req, output grant, grant_idx, grant_valid, preempt);

endinterface

// File: rtl/rr_arbiter4_dec.sv
// 2:4 one-hot decoder with enable; all-zero output when disabled.
module decoder2_4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]     sel,
  input  logic                 en,
  output logic [N_CLIENTS-1:0] y
);

  // One-hot decode of sel, gated by en
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end else begin
      y = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold limit and registered one-hot grant.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  arb_state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0]     owner_r, owner_nxt_s;
  logic [IDX_W-1:0]     last_r, last_nxt_s;
  logic [7:0]           hold_cnt_r, hold_nxt_s;
  logic                 preempt_nxt_s;
  logic [N_CLIENTS-1:0] own_mask_s, others_s, grant_nxt_s;
  logic [IDX_W:0]       pick_all_s, pick_oth_s;
  logic                 owned_nxt_s;
  logic [N_CLIENTS-1:0] grant_r;
  logic [IDX_W-1:0]     grant_idx_r;
  logic                 grant_valid_r, preempt_r;

  // Next-state arbitration; in OWNED, last equals owner so the owner is searched last and masked
  always_comb begin
    state_nxt_s   = state_r;
    owner_nxt_s   = owner_r;
    last_nxt_s    = last_r;
    hold_nxt_s    = hold_cnt_r;
    preempt_nxt_s = 1'b0;
    own_mask_s    = 4'b0001 << owner_r;
    others_s      = bus.req & ~own_mask_s;
    pick_all_s    = rr_pick(bus.req, last_r);
    pick_oth_s    = rr_pick(others_s, last_r);
    case (state_r)
      ARB_IDLE: begin
        if (pick_all_s[IDX_W]) begin
          state_nxt_s = ARB_OWNED;
          owner_nxt_s = pick_all_s[IDX_W-1:0];
          last_nxt_s  = pick_all_s[IDX_W-1:0];
          hold_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        if (!bus.req[owner_r]) begin
          if (pick_oth_s[IDX_W]) begin
            owner_nxt_s = pick_oth_s[IDX_W-1:0];
            last_nxt_s  = pick_oth_s[IDX_W-1:0];
          end else begin
            state_nxt_s = ARB_IDLE;
          end
          hold_nxt_s = 8'd0;
        end else if (!pick_oth_s[IDX_W]) begin
          hold_nxt_s = (hold_cnt_r >= HOLD_LIM) ? HOLD_LIM : hold_cnt_r + 8'd1;
        end else if (hold_cnt_r >= HOLD_LIM) begin
          owner_nxt_s   = pick_oth_s[IDX_W-1:0];
          last_nxt_s    = pick_oth_s[IDX_W-1:0];
          hold_nxt_s    = 8'd0;
          preempt_nxt_s = 1'b1;
        end else begin
          hold_nxt_s = hold_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
        hold_nxt_s  = 8'd0;
      end
    endcase
    owned_nxt_s = (state_nxt_s == ARB_OWNED);
  end

  decoder2_4 u_dec (
    .sel (owner_nxt_s),
    .en  (owned_nxt_s),
    .y   (grant_nxt_s)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ARB_IDLE;
      owner_r       <= 2'd0;
      last_r        <= 2'd3;
      hold_cnt_r    <= 8'd0;
      grant_r       <= 4'b0000;
      grant_idx_r   <= 2'd0;
      grant_valid_r <= 1'b0;
      preempt_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      owner_r       <= owner_nxt_s;
      last_r        <= last_nxt_s;
      hold_cnt_r    <= hold_nxt_s;
      grant_r       <= grant_nxt_s;
      grant_idx_r   <= owner_nxt_s;
      grant_valid_r <= owned_nxt_s;
      preempt_r     <= preempt_nxt_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = grant_idx_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.preempt     = preempt_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized plus directed bench for rr_arbiter4 against a cycle-level ownership model.
module tb_rr_arbiter4;

  localparam int M = 4;

  logic clk = 1'b0;
  logic rst;
  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: owner (-1 = none), last owner, cycles granted so far to current owner
  int m_owner = -1;
  int m_last  = 3;
  int m_held  = 0;
  bit m_pre   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    int w;
    m_pre = 1'b0;
    if (r_rst) begin
      m_owner = -1; m_last = 3; m_held = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_last, -1);
      if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
    end else if (!r[m_owner]) begin
      w = pick(r, m_last, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
      else m_owner = -1;
    end else begin
      w = pick(r, m_last, m_owner);
      if (w < 0) begin
        m_held = (m_held < M) ? m_held + 1 : M;
      end else if (m_held >= M) begin
        m_owner = w; m_last = w; m_held = 1; m_pre = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r, input string tag);
    logic [3:0] eg;
    rst     = r_rst;
    bus.req = r;
    @(posedge clk);
    model_step(r_rst, r);
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
    chk({tag, "/grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, "/valid"}, 32'(bus.grant_valid), 32'(m_owner >= 0));
    chk({tag, "/preempt"}, 32'(bus.preempt), 32'(m_pre));
    if (m_owner >= 0) chk({tag, "/idx"}, 32'(bus.grant_idx), 32'(m_owner));
  endtask

  logic [3:0] rq;

  initial begin
    rst     = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);

    step(1'b1, 4'b0000, "reset");
    chk("reset_grant", 32'(bus.grant), 32'h0);
    chk("reset_idx", 32'(bus.grant_idx), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, "idle");

    // Full contention rotates every M cycles starting from client 0
    step(1'b1, 4'b0000, "rst");
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 4'b1111, "rotate");
      chk("rot_grant", 32'(bus.grant), 32'(4'(4'b0001 << ((i / 4) % 4))));
      chk("rot_preempt", 32'(bus.preempt), 32'((i > 0) && (i % 4 == 0)));
    end

    step(1'b1, 4'b0000, "rst");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0100, "solo2");
      chk("solo2_grant", 32'(bus.grant), 32'h4);
    end

    // Release hands over with no dead cycle
    step(1'b1, 4'b0000, "rst");
    step(1'b0, 4'b0010, "rel_a");
    step(1'b0, 4'b1010, "rel_b");
    chk("rel_hold", 32'(bus.grant), 32'h2);
    step(1'b0, 4'b1000, "rel_c");
    chk("rel_switch", 32'(bus.grant), 32'h8);
    chk("rel_nopre", 32'(bus.preempt), 32'h0);

    // last = 1, then 0101 from idle serves client 2 first
    step(1'b1, 4'b0000, "rst");
    step(1'b0, 4'b0010, "last_a");
    step(1'b0, 4'b0000, "last_b");
    step(1'b0, 4'b0101, "last_c");
    chk("last_first", 32'(bus.grant), 32'h4);
    step(1'b0, 4'b0001, "last_d");
    chk("last_second", 32'(bus.grant), 32'h1);

    // Reset mid-ownership
    step(1'b1, 4'b0000, "rst");
    step(1'b0, 4'b0100, "mid_a");
    step(1'b1, 4'b0100, "mid_rst");
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_valid", 32'(bus.grant_valid), 32'h0);
    step(1'b0, 4'b1111, "mid_b");
    chk("mid_after", 32'(bus.grant), 32'h1);

    // Random traffic with sticky requests and occasional resets
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0) rq = 4'($urandom_range(15, 0));
      step(($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0, rq, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single resource among four clients and drives a one-hot grant through a 2:4 decoder. Sits between the requesting blocks and the shared resource (bus, memory port, display driver). Ownership is held while the owner keeps requesting, up to a programmable hold limit, after which a waiting requester is served. Grant outputs are registered.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while another requester waits; legal range 1..255.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request bit per client; level-sensitive.
- `grant`  output  4  one-hot grant; all-zero when no owner.
- `grant_idx`  output  2  binary index of the current owner; valid only when `grant_valid`.
- `grant_valid`  output  1  high while any grant is asserted.
- `preempt`  output  1  one-cycle pulse in the cycle ownership is taken away by hold-limit expiry.

## Operation
- States: IDLE (no owner), OWNED (one owner). Registers: `owner[1:0]`, `last[1:0]` (most recent owner), `hold_cnt[7:0]`, state.
- Arbitration: search `req` starting at `last+1` mod 4, wrapping; first asserted bit wins.
- IDLE: if any `req`, winner becomes owner, go OWNED, `hold_cnt`=0. Else stay IDLE.
- OWNED, owner's `req` low: release. If another `req` is high, arbitrate and grant the winner in the same transition (stay OWNED, `hold_cnt`=0); else go IDLE.
- OWNED, owner's `req` high, no other `req`: keep owner; `hold_cnt` saturates at `MAX_HOLD-1`.
- OWNED, owner's `req` high, other `req` pending: increment `hold_cnt`; when `hold_cnt == MAX_HOLD-1`, preempt: arbitrate excluding owner, grant winner, `hold_cnt`=0, pulse `preempt`.
- `last` updates to the new owner on every new grant; never updated in IDLE.
- `grant` = decoder output of `owner` with enable = (state == OWNED); never more than one bit set.
- `rst`: state IDLE, `owner`=0, `last`=3 (client 0 highest priority after reset), `hold_cnt`=0; all outputs 0. Reset mid-ownership drops the grant in the cycle after the `rst` edge; no preempt pulse.

## Timing
- Request-to-grant latency: `req` sampled at edge N drives `grant` from after edge N (visible in cycle N+1). No combinational path from `req` to `grant`.
- Release: owner drops `req` before edge N → `grant` bit clears after edge N; a waiting client receives `grant` after the same edge (zero dead cycles).
- With `MAX_HOLD`=M and continuous contention, owner holds exactly M cycles, then switches.
- `preempt` is high for exactly the first cycle of the new owner's grant.
- Simultaneous requests: order strictly by rotation from `last+1`; a client that asserts in the same cycle as release competes normally.
- Owner dropping `req` in the cycle the hold limit expires: treated as release (no `preempt`).
- Clients must hold `req` until granted; a request withdrawn before grant is simply not served.

## Structure
- Shared package `arb_pkg`: state enum (`ARB_IDLE`, `ARB_OWNED`), `N_CLIENTS`=4, index width constant.
- One sub-module instance: the existing `decoder2_4` for one-hot `grant` from `owner` with `en` = owned state. Rotating priority search is local combinational logic.

## Test plan
- Reset then `req`=4'b0000 for 5 cycles → `grant`=0, `grant_valid`=0, `preempt`=0 throughout.
- From reset, `req`=4'b1111 held, `MAX_HOLD`=4 → grant 0001 for 4 cycles, 0010 ×4, 0100 ×4, 1000 ×4, 0001; `preempt` pulses at each switch.
- Only `req[2]` held 20 cycles → `grant`=0100 continuously, `grant_idx`=2, no `preempt`.
- Owner 1 drops `req` while `req[3]` high → `grant` goes 0010 → 1000 on consecutive cycles, no idle cycle, no `preempt`.
- `last`=1, then `req`=4'b0101 from IDLE → client 2 granted first, then client 0 after release.
- Assert `rst` while `grant`=0100 → next cycle all outputs 0; following `req`=4'b1111 grants client 0.
